pocket_gamepad_encoder: RTL

- Transmit side of the Pocket 16-bit joypad word; the word is consumed by the gamepad-sync receiver.
- Takes 16 discrete raw button inputs (dev-board pins or test harness), synchronises and debounces each one, and packs them into the standard key-word bit order.
- Delivers the word to the downstream consumer with a valid/ready handshake, plus a continuously live copy.

---
 rtl/pocket_pad_pkg.sv | 29 ++
 rtl/pocket_pad_debounce.sv | 43 ++++
 rtl/pocket_gamepad_encoder.sv | 101 ++++++++++
 3 files changed

// File: rtl/pocket_pad_pkg.sv
// Shared definitions for the Pocket 16-bit joypad key word.
// Used by both the transmit-side encoder and the gamepad-sync receiver.
package pocket_pad_pkg;

    localparam int KEYW_W = 16;

    localparam int PAD_U  = 0;
    localparam int PAD_D  = 1;
    localparam int PAD_L  = 2;
    localparam int PAD_R  = 3;
    localparam int BTN_A  = 4;
    localparam int BTN_B  = 5;
    localparam int BTN_X  = 6;
    localparam int BTN_Y  = 7;
    localparam int BTN_L1 = 8;
    localparam int BTN_R1 = 9;
    localparam int BTN_L2 = 10;
    localparam int BTN_R2 = 11;
    localparam int BTN_L3 = 12;
    localparam int BTN_R3 = 13;
    localparam int BTN_SE = 14;
    localparam int BTN_ST = 15;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } hs_state_t;

endpackage

// File: rtl/pocket_pad_debounce.sv
// One key bit: 2-flop synchroniser followed by a stable-count debouncer.
// The debounced level moves only after DEBOUNCE_CYCLES consecutive differing samples.
module pocket_pad_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic [15:0] r_cnt;

    // Any sample that agrees with the debounced level restarts the count,
    // so the counter tops out at CNT_LAST and never wraps.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= 16'd0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= 16'd0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= 16'd0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/pocket_gamepad_encoder.sv
// Transmit side of the Pocket joypad word: debounced key word, change detect,
// valid/ready delivery with latest-wins coalescing and a sticky overrun flag.
module pocket_gamepad_encoder
    import pocket_pad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter bit ACTIVE_LOW_IN   = 1'b1
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic [15:0] iBTN,
    output logic [15:0] oJOY_LIVE,
    output logic [15:0] oJOY,
    output logic        oJOY_VALID,
    input  logic        iJOY_READY,
    output logic        oOVERRUN,
    output logic        oDBG_STATE
);

    // Handshake: a word moves when oJOY_VALID and iJOY_READY are both high at a
    // rising edge; oJOY is held stable while valid is high and ready is low.

    logic [KEYW_W-1:0] w_btn_hi;
    logic [KEYW_W-1:0] w_live;
    logic              w_dirty;
    logic              w_load;
    logic              w_set_ovr;
    hs_state_t         w_state_nxt;

    hs_state_t         r_state;
    logic [KEYW_W-1:0] r_joy;
    logic [KEYW_W-1:0] r_last;
    logic              r_ovr;

    assign w_btn_hi = ACTIVE_LOW_IN ? ~iBTN : iBTN;

    for (genvar g = 0; g < KEYW_W; g++) begin : g_bit
        pocket_pad_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .i_clk  (iCLK),
            .i_rst_n(iRSTn),
            .i_raw  (w_btn_hi[g]),
            .o_level(w_live[g])
        );
    end

    assign w_dirty = (w_live != r_last);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_set_ovr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dirty) begin
                    w_load      = 1'b1;
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                if (iJOY_READY) begin
                    // A change seen on the accept beat reloads with no bubble.
                    if (w_dirty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_dirty) begin
                    w_set_ovr = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            r_state <= IDLE;
            r_joy   <= '0;
            r_last  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_joy  <= w_live;
                r_last <= w_live;
            end
            if (w_set_ovr) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign oJOY_LIVE  = w_live;
    assign oJOY       = r_joy;
    assign oJOY_VALID = (r_state == PEND);
    assign oOVERRUN   = r_ovr;
    assign oDBG_STATE = r_state;

endmodule
